// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : pipe_ctrl
//  Brief   : Pipeline sequencing controller for the five-stage MIPS core.
//            Drives enables and clears for the F/D, D/E, E/M and M/W pipeline
//            registers. Schedules stalls for data hazards, mult/div
//            occupancy and wait-stated peripheral reads. Issues flushes and
//            PC redirects for exceptions, interrupts and eret in M.
//  Revision: 1.0  initial release
// ============================================================================
module pipe_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10,
   parameter int DEV_WAIT = 2
) (
   input  logic       clk,
   input  logic       reset,      // asynchronous, active low
   input  logic       stall_hz,
   input  logic       md_use_D,
   input  logic       md_start,
   input  logic       md_div,
   input  logic       dev_rd_M,
   input  logic       exc_req,
   input  logic       eret_M,
   output logic       en_F,
   output logic       en_D,
   output logic       en_E,
   output logic       en_M,
   output logic       clr_D,
   output logic       clr_E,
   output logic       clr_M,
   output logic       clr_W,
   output logic [1:0] pc_sel,
   output logic       md_busy
);

   // The mult/div counter must hold the larger of the two latencies.
   localparam int c_MD_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
   localparam int c_MDW    = (c_MD_MAX > 0) ? $clog2(c_MD_MAX + 1) : 1;
   localparam int c_DVW    = (DEV_WAIT > 0) ? $clog2(DEV_WAIT + 1) : 1;

   localparam logic [c_MDW-1:0] c_MULT_N   = c_MDW'(MULT_CYC);
   localparam logic [c_MDW-1:0] c_DIV_N    = c_MDW'(DIV_CYC);
   localparam logic [c_DVW-1:0] c_DEV_WAIT = c_DVW'(DEV_WAIT);

   localparam logic [1:0] c_PC_SEQ  = 2'b00;
   localparam logic [1:0] c_PC_EXC  = 2'b01;
   localparam logic [1:0] c_PC_EPC  = 2'b10;

   logic [c_MDW-1:0] r_md_cnt;
   logic [c_DVW-1:0] r_dev_cnt;

   logic w_dev_wait;
   logic w_md_stall;

   assign md_busy    = (r_md_cnt != '0);
   // With DEV_WAIT = 0 the compare is never true, so peripheral reads see no wait.
   assign w_dev_wait = dev_rd_M && (r_dev_cnt < c_DEV_WAIT);
   assign w_md_stall = md_use_D && (md_busy || md_start);

   // Prioritised pipeline control: exception > eret > device wait > md stall > hazard.
   always_comb begin
      en_F   = 1'b1;
      en_D   = 1'b1;
      en_E   = 1'b1;
      en_M   = 1'b1;
      clr_D  = 1'b0;
      clr_E  = 1'b0;
      clr_M  = 1'b0;
      clr_W  = 1'b0;
      pc_sel = c_PC_SEQ;
      if (exc_req) begin
         // Faulting instruction is squashed too, so W is cleared as well.
         clr_D  = 1'b1;
         clr_E  = 1'b1;
         clr_M  = 1'b1;
         clr_W  = 1'b1;
         pc_sel = c_PC_EXC;
      end else if (eret_M) begin
         // eret itself retires, so W keeps it.
         clr_D  = 1'b1;
         clr_E  = 1'b1;
         clr_M  = 1'b1;
         pc_sel = c_PC_EPC;
      end else if (w_dev_wait) begin
         // Freeze the whole pipe and feed W a bubble while the bridge waits.
         en_F  = 1'b0;
         en_D  = 1'b0;
         en_E  = 1'b0;
         en_M  = 1'b0;
         clr_W = 1'b1;
      end else if (w_md_stall || stall_hz) begin
         // Hold F and D, inject a bubble into E.
         en_F  = 1'b0;
         en_D  = 1'b0;
         clr_E = 1'b1;
      end
   end

   // Peripheral-read wait counter: counts held cycles, returns to 0 when the load proceeds.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dev_cnt <= '0;
      end else if (exc_req || eret_M) begin
         r_dev_cnt <= '0;
      end else if (w_dev_wait) begin
         r_dev_cnt <= r_dev_cnt + 1'b1;
      end else begin
         r_dev_cnt <= '0;
      end
   end

   // Mult/div occupancy counter: loads on start unless E is frozen, otherwise counts down.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_md_cnt <= '0;
      end else if (exc_req) begin
         r_md_cnt <= '0;
      end else if (md_start && !md_busy && !w_dev_wait) begin
         r_md_cnt <= md_div ? c_DIV_N : c_MULT_N;
      end else if (md_busy) begin
         r_md_cnt <= r_md_cnt - 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pipe_ctrl
//  Brief   : Self-checking bench for pipe_ctrl (default parameters).
//  Revision: 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

   logic       clk;
   logic       reset;
   logic       stall_hz, md_use_D, md_start, md_div, dev_rd_M, exc_req, eret_M;
   logic       en_F, en_D, en_E, en_M, clr_D, clr_E, clr_M, clr_W, md_busy;
   logic [1:0] pc_sel;

   int passed;
   int total;

   // Output word: {en_F,en_D,en_E,en_M, clr_D,clr_E,clr_M,clr_W, pc_sel, md_busy}
   localparam logic [10:0] IDLE   = 11'b1111_0000_00_0;
   localparam logic [10:0] STALL  = 11'b0011_0100_00_0;
   localparam logic [10:0] STALLB = 11'b0011_0100_00_1;
   localparam logic [10:0] DEVW   = 11'b0000_0001_00_0;
   localparam logic [10:0] EXC    = 11'b1111_1111_01_0;
   localparam logic [10:0] EXCB   = 11'b1111_1111_01_1;
   localparam logic [10:0] ERET   = 11'b1111_1110_10_0;
   localparam logic [10:0] IDLEB  = 11'b1111_0000_00_1;

   // Input word: {stall_hz, md_use_D, md_start, md_div, dev_rd_M, exc_req, eret_M}
   typedef struct packed {
      logic [6:0]  in;
      logic [10:0] exp;
   } vec_t;

   pipe_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .DEV_WAIT(2)) dut (
      .clk(clk), .reset(reset),
      .stall_hz(stall_hz), .md_use_D(md_use_D), .md_start(md_start), .md_div(md_div),
      .dev_rd_M(dev_rd_M), .exc_req(exc_req), .eret_M(eret_M),
      .en_F(en_F), .en_D(en_D), .en_E(en_E), .en_M(en_M),
      .clr_D(clr_D), .clr_E(clr_E), .clr_M(clr_M), .clr_W(clr_W),
      .pc_sel(pc_sel), .md_busy(md_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [10:0] actual();
      return {en_F, en_D, en_E, en_M, clr_D, clr_E, clr_M, clr_W, pc_sel, md_busy};
   endfunction

   task automatic drive(input logic [6:0] v);
      {stall_hz, md_use_D, md_start, md_div, dev_rd_M, exc_req, eret_M} = v;
   endtask

   task automatic check(input string name, input logic [10:0] exp);
      logic [10:0] act;
      act = actual();
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   // Drive a vector just after the falling edge and check 2 ns later.
   task automatic step(input logic [6:0] v, input string name, input logic [10:0] exp);
      @(negedge clk);
      drive(v);
      #2;
      check(name, exp);
   endtask

   // Mult/div start followed by a held HI/LO user in D.
   task automatic md_seq(input logic div, input int n, input string name);
      step({1'b0, 1'b1, 1'b1, div, 3'b000}, {name, "_start"}, STALL);
      for (int i = 1; i <= n; i++)
         step({1'b0, 1'b1, 1'b0, div, 3'b000}, $sformatf("%s_busy%0d", name, i), STALLB);
      step({1'b0, 1'b1, 1'b0, div, 3'b000}, {name, "_release"}, IDLE);
      step(7'b0, {name, "_idle"}, IDLE);
   endtask

   vec_t vecs [13];

   initial begin
      passed = 0;
      total  = 0;

      vecs[0]  = '{7'b000_0000, IDLE};   // idle
      vecs[1]  = '{7'b100_0000, STALL};  // hazard stall
      vecs[2]  = '{7'b011_0000, STALL};  // md user in D while mult enters E
      vecs[3]  = '{7'b010_0000, IDLE};   // md user, unit idle
      vecs[4]  = '{7'b001_0000, IDLE};   // start alone does not stall
      vecs[5]  = '{7'b000_0100, DEVW};   // device read, first wait cycle
      vecs[6]  = '{7'b100_0100, DEVW};   // hazard during device wait
      vecs[7]  = '{7'b000_0010, EXC};    // exception
      vecs[8]  = '{7'b000_0110, EXC};    // exception beats device wait
      vecs[9]  = '{7'b000_0001, ERET};   // eret
      vecs[10] = '{7'b100_0001, ERET};   // eret beats hazard stall
      vecs[11] = '{7'b000_0011, EXC};    // exception beats eret
      vecs[12] = '{7'b011_0100, DEVW};   // device wait beats md stall

      // Reset held for 3 cycles with random inputs: counters stay clear.
      reset = 1'b0;
      drive(7'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(7'($urandom));
         #2;
         total++;
         if (md_busy === 1'b0) passed++;
         else $display("FAIL reset_busy%0d: got %b expected 0", i, md_busy);
      end
      @(negedge clk);
      drive(7'b0);
      reset = 1'b1;
      #2;
      check("reset_idle", IDLE);
      step(7'b0, "post_reset_idle", IDLE);

      // Single-cycle vectors from a clean state; an async reset pulse clears any counter effect.
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         drive(vecs[i].in);
         #2;
         check($sformatf("vec%0d", i), vecs[i].exp);
         drive(7'b0);
         reset = 1'b0;
         #1;
         reset = 1'b1;
      end

      md_seq(1'b0, 5, "mult");
      md_seq(1'b1, 10, "div");

      // Device read held: two wait cycles, load proceeds, next read waits again.
      step(7'b000_0100, "dev_w0", DEVW);
      step(7'b000_0100, "dev_w1", DEVW);
      step(7'b000_0100, "dev_go", IDLE);
      step(7'b000_0100, "dev_next_w0", DEVW);
      step(7'b000_0000, "dev_done", IDLE);

      // Exception in the second wait cycle aborts the wait.
      step(7'b000_0100, "exc_w0", DEVW);
      step(7'b000_0110, "exc_hit", EXC);
      step(7'b000_0100, "exc_after_w0", DEVW);
      step(7'b000_0100, "exc_after_w1", DEVW);
      step(7'b000_0100, "exc_after_go", IDLE);
      step(7'b0, "exc_idle", IDLE);

      // Exception while mult/div busy clears the unit.
      step(7'b001_0000, "excmd_start", IDLE);
      step(7'b000_0010, "excmd_hit", EXCB);
      step(7'b0, "excmd_cleared", IDLE);

      // Start while E is frozen by a device wait is not accepted.
      step(7'b001_0100, "mddev_start", DEVW);
      step(7'b0, "mddev_noload", IDLE);

      // Mult/div keeps counting through a device wait.
      step(7'b001_1000, "mddev2_start", IDLE);
      step(7'b000_0100, "mddev2_w0", 11'b0000_0001_00_1);
      step(7'b000_0100, "mddev2_w1", 11'b0000_0001_00_1);
      step(7'b000_0100, "mddev2_go", IDLEB);
      for (int i = 4; i <= 10; i++)
         step(7'b0, $sformatf("mddev2_c%0d", i), IDLEB);
      step(7'b0, "mddev2_end", IDLE);

      // Reset asserted mid-stall forces idle outputs immediately.
      step(7'b011_1000, "rst_mid_start", STALL);
      step(7'b010_1000, "rst_mid_busy", STALLB);
      reset = 1'b0;
      #1;
      check("rst_mid_forced", IDLE);
      @(negedge clk);
      reset = 1'b1;
      drive(7'b0);
      #2;
      check("rst_mid_release", IDLE);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Absolute time limit so the bench always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
